// File: rtl/muldiv_issue.sv
// -----------------------------------------------------------------------------
// muldiv_issue
//
// In-order issue queue in front of the multiply/divide unit. Holds up to DEPTH
// requests with their operand values. It drives the unit's issue port with at
// most one op per cycle. Divides are held back while the single divider is busy.
// Killed entries (commit_kill_0) are marked dead and dropped without being issued.
//
// Optional feature: define MULDIV_BYPASS_EN to let the mul-class entry directly
// behind a blocked divide issue ahead of it. That entry is marked done and pops
// silently when it later reaches the head. Without the macro, issue is strictly
// in order.
//
// Ports
//   clk            clock
//   reset          synchronous, active-low reset
//   in_valid       request present
//   in_ready       queue can accept (registered occupancy only)
//   in_control     op encoding (bit 0 = mul, bit 5 = bit-manip)
//   in_rd          destination commit register
//   in_makes_rd    op writes rd
//   in_r1, in_r2   operand values
//   in_hart        owning hart
//   commit_kill_0  per-commit-register kill
//   divide_busy    divider occupied (from the unit)
//   enable         issue strobe to the unit
//   control, rd, makes_rd, r1, r2, hart   issued op fields (valid with enable)
//   empty          no entries held
// -----------------------------------------------------------------------------
module muldiv_issue #(
  parameter int CNTRL_SIZE = 7,
  parameter int RV         = 64,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int DEPTH      = 4,
  parameter int LDEPTH     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CNTRL_SIZE-1:0]                in_control,
  input  logic [LNCOMMIT-1:0]                  in_rd,
  input  logic                                 in_makes_rd,
  input  logic [RV-1:0]                        in_r1,
  input  logic [RV-1:0]                        in_r2,
  input  logic [(NHART==1?0:LNHART-1):0]       in_hart,
  input  logic [NCOMMIT-1:0]                   commit_kill_0,
  input  logic                                 divide_busy,
  output logic                                 enable,
  output logic [CNTRL_SIZE-1:0]                control,
  output logic [LNCOMMIT-1:0]                  rd,
  output logic                                 makes_rd,
  output logic [RV-1:0]                        r1,
  output logic [RV-1:0]                        r2,
  output logic [(NHART==1?0:LNHART-1):0]       hart,
  output logic                                 empty
);

  localparam int              HW       = (NHART == 1) ? 1 : LNHART;
  localparam logic [LDEPTH:0] FULL_CNT = (LDEPTH+1)'(DEPTH);
  localparam logic [LDEPTH:0] CNT_ONE  = (LDEPTH+1)'(1);
  localparam logic [LDEPTH-1:0] PTR_ONE = LDEPTH'(1);

  // Entry payload (written on push only, qualified by valid_q)
  logic [CNTRL_SIZE-1:0] ctrl_q  [DEPTH];
  logic [LNCOMMIT-1:0]   rd_q    [DEPTH];
  logic [RV-1:0]         r1_q    [DEPTH];
  logic [RV-1:0]         r2_q    [DEPTH];
  logic [HW-1:0]         hart_q  [DEPTH];
  logic [DEPTH-1:0]      makes_rd_q;

  // Entry flags
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] dead_q, dead_d;
  logic [DEPTH-1:0] done_q, done_d;

  logic [LDEPTH-1:0] head_q, head_d;
  logic [LDEPTH-1:0] tail_q, tail_d;
  logic [LDEPTH:0]   count_q, count_d;
  logic              div_shadow_q, div_shadow_d;

  function automatic logic is_div_f(input logic [CNTRL_SIZE-1:0] c);
    return !c[0] && !c[5];
  endfunction

  // Kill lookup per slot; gated by valid where it updates state.
  logic [DEPTH-1:0] kill_hit;
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
      assign kill_hit[gi] = commit_kill_0[rd_q[gi]];
    end
  endgenerate

  logic head_valid, head_retired, head_live, head_div, div_block;
  logic head_issue, issue_bypass, push, pop;
  logic [LDEPTH-1:0] issue_idx;

  assign head_valid   = valid_q[head_q];
  assign head_retired = dead_q[head_q] | done_q[head_q];
  // A kill arriving this cycle suppresses issue; the entry pops next cycle as dead.
  assign head_live    = head_valid && !head_retired && !kill_hit[head_q];
  assign head_div     = is_div_f(ctrl_q[head_q]);
  assign div_block    = divide_busy | div_shadow_q;
  assign head_issue   = head_live && (!head_div || !div_block);
  assign pop          = head_issue || (head_valid && head_retired);

`ifdef MULDIV_BYPASS_EN
  logic [LDEPTH-1:0] next_idx;
  assign next_idx     = head_q + PTR_ONE;
  // Only the entry directly behind a live divide blocked by the divider may pass it.
  assign issue_bypass = head_live && head_div && div_block &&
                        valid_q[next_idx] && !dead_q[next_idx] && !done_q[next_idx] &&
                        !kill_hit[next_idx] && !is_div_f(ctrl_q[next_idx]);
  assign issue_idx    = issue_bypass ? next_idx : head_q;
`else
  assign issue_bypass = 1'b0;
  assign issue_idx    = head_q;
`endif

  assign enable   = head_issue | issue_bypass;
  assign control  = ctrl_q[issue_idx];
  assign rd       = rd_q[issue_idx];
  assign makes_rd = makes_rd_q[issue_idx];
  assign r1       = r1_q[issue_idx];
  assign r2       = r2_q[issue_idx];
  assign hart     = hart_q[issue_idx];

  // Ready comes from registered occupancy only: no pop-through when full.
  assign in_ready = (count_q != FULL_CNT);
  assign empty    = (count_q == '0);
  assign push     = in_valid && in_ready;

  always_comb begin
    valid_d      = valid_q;
    dead_d       = dead_q | (valid_q & kill_hit);
    done_d       = done_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    // Covers the cycle between a divide issue and the unit raising divide_busy.
    div_shadow_d = head_issue && head_div;

    if (issue_bypass) begin
      done_d[issue_idx] = 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      dead_d[head_q]  = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + PTR_ONE;
    end
    // Push never targets the popped slot: push needs not-full, pop needs non-empty.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      dead_d[tail_q]  = commit_kill_0[in_rd];
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= '0;
      dead_q       <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      div_shadow_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      dead_q       <= dead_d;
      done_q       <= done_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      div_shadow_q <= div_shadow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_q[tail_q]     <= in_control;
      rd_q[tail_q]       <= in_rd;
      makes_rd_q[tail_q] <= in_makes_rd;
      r1_q[tail_q]       <= in_r1;
      r2_q[tail_q]       <= in_r2;
      hart_q[tail_q]     <= in_hart;
    end
  end

endmodule

// File: tb/tb_muldiv_issue.sv
module tb_muldiv_issue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_control;
  logic [4:0]  in_rd;
  logic        in_makes_rd;
  logic [63:0] in_r1, in_r2;
  logic [0:0]  in_hart;
  logic [31:0] commit_kill_0;
  logic        divide_busy;
  logic        enable;
  logic [6:0]  control;
  logic [4:0]  rd;
  logic        makes_rd;
  logic [63:0] r1, r2;
  logic [0:0]  hart;
  logic        empty;

  muldiv_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_rd(in_rd), .in_makes_rd(in_makes_rd),
    .in_r1(in_r1), .in_r2(in_r2), .in_hart(in_hart),
    .commit_kill_0(commit_kill_0), .divide_busy(divide_busy),
    .enable(enable), .control(control), .rd(rd), .makes_rd(makes_rd),
    .r1(r1), .r2(r2), .hart(hart), .empty(empty)
  );

  localparam logic [6:0] C_MUL = 7'b0000001;
  localparam logic [6:0] C_DIV = 7'b0000010;
  localparam logic [6:0] C_BM  = 7'b0100000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [6:0] c, input logic [4:0] r,
                       input logic [31:0] kill, input bit busy);
    in_valid      = v;
    in_control    = c;
    in_rd         = r;
    in_makes_rd   = 1'($urandom_range(0, 1));
    in_r1         = {$urandom, $urandom};
    in_r2         = {$urandom, $urandom};
    in_hart       = 1'($urandom_range(0, 1));
    commit_kill_0 = kill;
    divide_busy   = busy;
  endtask

  task automatic idle(input bit busy);
    drive(1'b0, C_MUL, 5'd0, 32'd0, busy);
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Check one cycle's outputs at the falling edge, then advance past the next rising edge.
  task automatic expect_cycle(input string tag, input bit e_en, input logic [4:0] e_rd,
                              input bit e_rdy, input bit e_emp);
    @(negedge clk);
    chk({tag, ".enable"}, 160'(enable), 160'(e_en));
    if (e_en) chk({tag, ".rd"}, 160'(rd), 160'(e_rd));
    chk({tag, ".in_ready"}, 160'(in_ready), 160'(e_rdy));
    chk({tag, ".empty"}, 160'(empty), 160'(e_emp));
    tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         v;
    logic [6:0] c;
    logic [4:0] rd;
    bit         ke;
    logic [4:0] kr;
    bit         busy;
    bit         e_en;
    logic [4:0] e_rd;
    bit         e_rdy;
    bit         e_emp;
  } vec_t;

  function automatic vec_t mk(bit v, logic [6:0] c, logic [4:0] r, bit ke, logic [4:0] kr,
                              bit busy, bit een, logic [4:0] erd, bit erdy, bit eemp);
    vec_t t;
    t.v = v; t.c = c; t.rd = r; t.ke = ke; t.kr = kr; t.busy = busy;
    t.e_en = een; t.e_rd = erd; t.e_rdy = erdy; t.e_emp = eemp;
    return t;
  endfunction

  vec_t tbl [25];

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]  c;
    logic [4:0]  rd;
    logic        mk;
    logic [63:0] a;
    logic [63:0] b;
    logic [0:0]  h;
    bit          dead;
    bit          done;
  } ent_t;

  ent_t mq[$];
  bit   m_shadow;

  function automatic bit is_div(input logic [6:0] c);
    return !c[0] && !c[5];
  endfunction

  task automatic model_eval(output bit en, output int idx, output bit pop);
    en = 0; idx = 0; pop = 0;
    if (mq.size() > 0) begin
      if (mq[0].dead || mq[0].done) begin
        pop = 1;
      end else if (!commit_kill_0[mq[0].rd]) begin
        if (!is_div(mq[0].c) || !(divide_busy || m_shadow)) begin
          en = 1; pop = 1;
        end
`ifdef MULDIV_BYPASS_EN
        else if (mq.size() > 1 && !mq[1].dead && !mq[1].done &&
                 !commit_kill_0[mq[1].rd] && !is_div(mq[1].c)) begin
          en = 1; idx = 1;
        end
`endif
      end
    end
  endtask

  task automatic model_step(input bit en, input int idx, input bit pop);
    bit   acc;
    ent_t t;
    acc = in_valid && (mq.size() != 4);
    m_shadow = 0;
    if (en && idx == 0) m_shadow = is_div(mq[0].c);
    if (en && idx == 1) begin
      t = mq[1]; t.done = 1; mq[1] = t;
    end
    if (pop) void'(mq.pop_front());
    for (int i = 0; i < mq.size(); i++) begin
      if (commit_kill_0[mq[i].rd]) begin
        t = mq[i]; t.dead = 1; mq[i] = t;
      end
    end
    if (acc) begin
      t.c = in_control; t.rd = in_rd; t.mk = in_makes_rd; t.a = in_r1; t.b = in_r2;
      t.h = in_hart; t.dead = commit_kill_0[in_rd]; t.done = 0;
      mq.push_back(t);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(1'b0);

    //             v  ctrl   rd  ke kr busy  en rd  rdy emp
    tbl[0]  = mk(1, C_MUL, 3,  0, 0, 0,   0, 0,  1, 1);
    tbl[1]  = mk(0, C_MUL, 0,  0, 0, 0,   1, 3,  1, 0);
    tbl[2]  = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 1);
    tbl[3]  = mk(1, C_MUL, 9,  1, 9, 0,   0, 0,  1, 1);
    tbl[4]  = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 0);
    tbl[5]  = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 1);
    tbl[6]  = mk(1, C_MUL, 7,  0, 0, 0,   0, 0,  1, 1);
    tbl[7]  = mk(1, C_MUL, 8,  1, 7, 0,   0, 0,  1, 0);
    tbl[8]  = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 0);
    tbl[9]  = mk(0, C_MUL, 0,  0, 0, 0,   1, 8,  1, 0);
    tbl[10] = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 1);
    tbl[11] = mk(1, C_DIV, 5,  0, 0, 1,   0, 0,  1, 1);
    tbl[12] = mk(1, C_DIV, 6,  0, 0, 1,   0, 0,  1, 0);
    tbl[13] = mk(1, C_DIV, 10, 0, 0, 1,   0, 0,  1, 0);
    tbl[14] = mk(1, C_DIV, 11, 0, 0, 1,   0, 0,  1, 0);
    tbl[15] = mk(1, C_DIV, 12, 0, 0, 1,   0, 0,  0, 0);
    tbl[16] = mk(0, C_MUL, 0,  0, 0, 0,   1, 5,  0, 0);
    tbl[17] = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 0);
    tbl[18] = mk(0, C_MUL, 0,  0, 0, 1,   0, 0,  1, 0);
    tbl[19] = mk(0, C_MUL, 0,  0, 0, 0,   1, 6,  1, 0);
    tbl[20] = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 0);
    tbl[21] = mk(0, C_MUL, 0,  0, 0, 0,   1, 10, 1, 0);
    tbl[22] = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 0);
    tbl[23] = mk(0, C_MUL, 0,  0, 0, 0,   1, 11, 1, 0);
    tbl[24] = mk(0, C_MUL, 0,  0, 0, 0,   0, 0,  1, 1);

    // Reset state, sampled while reset is still low.
    tick();
    @(negedge clk);
    chk("reset.enable", 160'(enable), 160'(0));
    chk("reset.in_ready", 160'(in_ready), 160'(1));
    chk("reset.empty", 160'(empty), 160'(1));
    tick();
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      logic [31:0] kv;
      kv = tbl[i].ke ? (32'd1 << tbl[i].kr) : 32'd0;
      drive(tbl[i].v, tbl[i].c, tbl[i].rd, kv, tbl[i].busy);
      expect_cycle($sformatf("tbl%0d", i), tbl[i].e_en, tbl[i].e_rd, tbl[i].e_rdy, tbl[i].e_emp);
      $display("tbl %0d: v=%0d rd=%0d busy=%0d -> en=%0d rd=%0d", i, tbl[i].v, tbl[i].rd,
               tbl[i].busy, tbl[i].e_en, tbl[i].e_rd);
    end

    // Two divides; divider busy for 20 cycles after the first issue.
    do_reset();
    drive(1, C_DIV, 5, 0, 0); expect_cycle("div2.push5", 0, 0, 1, 1);
    drive(1, C_DIV, 6, 0, 0); expect_cycle("div2.iss5", 1, 5, 1, 0);
    for (int i = 0; i < 20; i++) begin
      idle(1'b1);
      expect_cycle($sformatf("div2.hold%0d", i), 0, 0, 1, 0);
    end
    idle(1'b0); expect_cycle("div2.iss6", 1, 6, 1, 0);
    idle(1'b0); expect_cycle("div2.drained", 0, 0, 1, 1);
    $display("div2: rd6 held for 20 busy cycles");

    // Mul behind a blocked divide.
    do_reset();
    drive(1, C_DIV, 10, 0, 1); expect_cycle("byp.push10", 0, 0, 1, 1);
    drive(1, C_MUL, 11, 0, 1); expect_cycle("byp.push11", 0, 0, 1, 0);
`ifdef MULDIV_BYPASS_EN
    idle(1'b1); expect_cycle("byp.iss11", 1, 11, 1, 0);
    idle(1'b0); expect_cycle("byp.iss10", 1, 10, 1, 0);
    idle(1'b0); expect_cycle("byp.pop11", 0, 0, 1, 0);
`else
    idle(1'b1); expect_cycle("byp.wait", 0, 0, 1, 0);
    idle(1'b0); expect_cycle("byp.iss10", 1, 10, 1, 0);
    idle(1'b0); expect_cycle("byp.iss11", 1, 11, 1, 0);
`endif
    idle(1'b0); expect_cycle("byp.empty", 0, 0, 1, 1);
    $display("bypass sequence done");

    // Reset mid-operation discards held entries.
    do_reset();
    drive(1, C_DIV, 1, 0, 1); tick();
    drive(1, C_DIV, 2, 0, 1); tick();
    drive(1, C_DIV, 3, 0, 1); tick();
    idle(1'b1);
    @(negedge clk);
    chk("midrst.held", 160'(empty), 160'(0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle(1'b0);
    expect_cycle("midrst.after", 0, 0, 1, 1);
    $display("mid-operation reset done");

    // Randomized run against the queue model.
    do_reset();
    mq.delete();
    m_shadow = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit          e_en, e_pop;
      int          e_idx;
      logic [6:0]  c;
      logic [31:0] kv;
      logic [159:0] act_f, exp_f;
      case ($urandom_range(0, 3))
        0: c = C_MUL;
        1: c = C_DIV;
        2: c = C_BM;
        default: c = 7'($urandom);
      endcase
      kv = ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'd0;
      drive($urandom_range(0, 9) < 6, c, 5'($urandom_range(0, 7)), kv, $urandom_range(0, 3) == 0);
      model_eval(e_en, e_idx, e_pop);
      @(negedge clk);
      chk("rnd.enable", 160'(enable), 160'(e_en));
      chk("rnd.in_ready", 160'(in_ready), 160'(mq.size() != 4));
      chk("rnd.empty", 160'(empty), 160'(mq.size() == 0));
      if (e_en) begin
        act_f = 160'({control, rd, makes_rd, r1, r2, hart});
        exp_f = 160'({mq[e_idx].c, mq[e_idx].rd, mq[e_idx].mk, mq[e_idx].a, mq[e_idx].b, mq[e_idx].h});
        chk("rnd.fields", act_f, exp_f);
        $display("rnd %0d: issue rd=%0d ctrl=%b slot=%0d", cyc, mq[e_idx].rd, mq[e_idx].c, e_idx);
      end
      model_step(e_en, e_idx, e_pop);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
